sr_flag_arbiter: RTL and testbench
==================================

Name: sr_flag_arbiter

Overview:
Bank of N SR-style status flags with a round-robin service arbiter.
- Each flag is set and cleared by event requests, gated by a global Enable, in the same way as the bank's SR latch cells.
- Masked, pending flags are offered one at a time to a single downstream consumer over a valid/ready grant handshake.
- Sits between event sources (set/clear requesters) and the shared service engine that drains them.

Parameters:
N, 4, number of flags and requesters (2..16)
IDW, $clog2(N), width of grant_id

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
Enable  input  1  global update gate; 0 = all flags hold (opaque)
set_req  input  N  per-flag set request
clr_req  input  N  per-flag clear request
mask  input  N  per-flag service enable; 1 = eligible for grant
grant_ready  input  1  consumer accepts current grant
grant_valid  output  1  a grant is being offered
grant_id  output  IDW  index of granted flag
flags  output  N  current flag state (registered)
conflict  output  N  sticky: S=R=1 seen while Enable=1
pending  output  1  |(flags & mask), combinational from registers

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On a rst edge: flags=0, conflict=0, grant_valid=0, grant_id=0, state=IDLE, rr pointer=N-1 (so the first search starts at 0). Reset overrides all other inputs, including mid-grant.
- Flag update, per bit i, evaluated each edge, first match wins:
  - Enable=0: hold. Requests and handshakes do not change flags; a handshake still completes in the FSM.
  - set_req=1, clr_req=0: flag=1.
  - set_req=0, clr_req=1: flag=0.
  - set_req=1, clr_req=1: flag holds; conflict[i]=1 (sticky until rst).
  - otherwise, if a handshake for i occurs this cycle: flag=0. A set_req in the same cycle wins (flag=1, treated as a new event).
  - otherwise: hold.
- Arbiter FSM, two states:
  - IDLE: if (flags & mask)!=0, select the first set bit searching upward from ptr+1 with wrap-around. Register grant_id=sel, grant_valid=1, go to GRANT. Otherwise stay, grant_valid=0.
  - GRANT: grant_valid=1 and grant_id held stable until grant_ready=1, even if that flag is cleared or masked meanwhile. Handshake = grant_valid & grant_ready. On handshake: ptr=grant_id, grant_valid=0 next cycle, return to IDLE.
- Timing:
  - One bubble cycle between consecutive grants.
  - Latency: set_req at edge t -> flags bit at t+1 -> grant_valid at t+2.
- Boundary cases:
  - Mask change during GRANT does not withdraw the grant.
  - Only one eligible flag: it is re-granted each time it is set, regardless of ptr.
  - ptr wrap: after granting N-1, search starts at 0.
  - All-zero mask: pending=0, FSM stays in IDLE indefinitely.

Decomposition:
- Package sr_flag_pkg: state enum {IDLE, GRANT}, default N, IDW derivation.
- Sub-module rr_pick: purely combinational round-robin picker. Inputs: req[N], ptr[IDW]. Outputs: any, sel[IDW].
- Flag update and FSM stay in sr_flag_arbiter.

Test Plan:
- Reset: rst=1 for 2 cycles with set_req=1111 -> flags=0000, conflict=0000, grant_valid=0, pending=0.
- Enable gating: Enable=0, set_req=0101 for 3 cycles -> flags=0000. Then Enable=1, set_req=0101 for 1 cycle -> flags=0101 next cycle; grant_valid=1, grant_id=0 one cycle later.
- Round-robin: flags=1111, mask=1111, grant_ready=1 constantly -> grant_id sequence 0,2... no: 0,1,2,3, each followed by one idle cycle, with flags clearing bit-by-bit to 0000. Re-set 1111 -> next grant_id=0 (ptr wrapped).
- Conflict: Enable=1, set_req[2]=clr_req[2]=1, flags[2]=0 -> flags[2] stays 0, conflict=0100, which persists after requests drop until rst.
- Backpressure and priority: grant on id 1 with grant_ready=0 for 5 cycles while set_req[0] pulses -> grant_id stays 1, grant_valid stays 1. On ready, flags[1]=0; next grant_id=0 (wrap from ptr=1 with only bit 0 eligible). Handshake on id 3 together with set_req[3] -> flags[3] stays 1.
- Mask and mid-op reset: flags=0010, mask=0000 -> pending=0, no grant. Set mask=0010 -> grant id 1. Assert rst during GRANT -> grant_valid=0 and flags=0000 on the next edge.

Source files
------------

// File: rtl/sr_flag_pkg.sv
// rtl/sr_flag_pkg.sv - shared types and sizing helpers for the SR flag arbiter
package sr_flag_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // grant_id width for a bank of n flags
    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker searching upward from ptr+1
module rr_pick
    import sr_flag_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] sel
);

    logic [IDW-1:0] idx;
    logic           found;

    // first requester after ptr, wrapping; ptr itself is checked last
    always_comb begin
        any   = |req;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - SR status flag bank with round-robin valid/ready grant
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int N   = N_DEFAULT,
    parameter int IDW = idw_of(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           Enable,
    input  logic [N-1:0]   set_req,
    input  logic [N-1:0]   clr_req,
    input  logic [N-1:0]   mask,
    input  logic           grant_ready,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   flags,
    output logic [N-1:0]   conflict,
    output logic           pending
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   flags_q, flags_d;
    logic [N-1:0]   conflict_q, conflict_d;

    logic [N-1:0]   eligible;
    logic           pick_any;
    logic [IDW-1:0] pick_sel;
    logic           handshake;

    assign eligible    = flags_q & mask;
    assign grant_valid = (state_q == GRANT);
    assign handshake   = grant_valid & grant_ready;
    assign grant_id    = grant_id_q;
    assign flags       = flags_q;
    assign conflict    = conflict_q;
    assign pending     = |eligible;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req (eligible),
        .ptr (ptr_q),
        .any (pick_any),
        .sel (pick_sel)
    );

    // per-flag SR update; a serviced flag self-clears unless re-set that cycle
    always_comb begin
        flags_d    = flags_q;
        conflict_d = conflict_q;
        if (Enable) begin
            for (int i = 0; i < N; i++) begin
                case ({set_req[i], clr_req[i]})
                    2'b10:   flags_d[i]    = 1'b1;
                    2'b01:   flags_d[i]    = 1'b0;
                    2'b11:   conflict_d[i] = 1'b1;
                    default: begin
                        if (handshake && (grant_id_q == IDW'(i))) begin
                            flags_d[i] = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    // arbiter next state: grant is latched in IDLE and held until accepted
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_sel;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    ptr_d   = grant_id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; ptr resets to N-1 so the first search starts at 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            ptr_q      <= IDW'(N - 1);
            flags_q    <= '0;
            conflict_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
            flags_q    <= flags_d;
            conflict_q <= conflict_d;
        end
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - self-checking bench for sr_flag_arbiter
module tb_sr_flag_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           Enable;
    logic [N-1:0]   set_req;
    logic [N-1:0]   clr_req;
    logic [N-1:0]   mask;
    logic           grant_ready;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [N-1:0]   flags;
    logic [N-1:0]   conflict;
    logic           pending;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (spec-level)
    logic [N-1:0] m_flags;
    logic [N-1:0] m_conf;
    logic         m_valid;
    int           m_id;
    int           m_ptr;

    sr_flag_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk         (clk),
        .rst         (rst),
        .Enable      (Enable),
        .set_req     (set_req),
        .clr_req     (clr_req),
        .mask        (mask),
        .grant_ready (grant_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .flags       (flags),
        .conflict    (conflict),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // advance one clock; the model applies the spec rules to the pre-edge inputs
    task automatic step();
        logic [N-1:0] nf;
        logic [N-1:0] nc;
        logic         nv;
        int           nid;
        int           np;
        bit           hs;
        nf = m_flags; nc = m_conf; nv = m_valid; nid = m_id; np = m_ptr;
        if (rst) begin
            nf = '0; nc = '0; nv = 1'b0; nid = 0; np = N - 1;
        end else begin
            hs = m_valid && grant_ready;
            if (Enable) begin
                for (int i = 0; i < N; i++) begin
                    if (set_req[i] && !clr_req[i])      nf[i] = 1'b1;
                    else if (!set_req[i] && clr_req[i]) nf[i] = 1'b0;
                    else if (set_req[i] && clr_req[i])  nc[i] = 1'b1;
                    else if (hs && m_id == i)           nf[i] = 1'b0;
                end
            end
            if (m_valid) begin
                if (grant_ready) begin
                    nv = 1'b0;
                    np = m_id;
                end
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (m_ptr + k) % N;
                    if (!nv && m_flags[j] && mask[j]) begin
                        nv  = 1'b1;
                        nid = j;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        m_flags = nf; m_conf = nc; m_valid = nv; m_id = nid; m_ptr = np;
    endtask

    task automatic do_reset();
        rst = 1'b1; Enable = 1'b1; set_req = '0; clr_req = '0;
        mask = '1; grant_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; Enable = 1'b1; set_req = 4'b1111; clr_req = '0;
        mask = 4'b1111; grant_ready = 1'b0;
        step(); step();
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", flags); end
        n_checks++; if (conflict !== 4'b0000) begin n_fail++; $display("FAIL reset_conflict got %b exp 0000", conflict); end
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", grant_valid); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", pending); end
        rst = 1'b0; set_req = '0;
    endtask

    task automatic test_enable_gating();
        do_reset();
        Enable = 1'b0; set_req = 4'b0101;
        repeat (3) step();
        n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL en_hold got %b exp 0000", flags); end
        Enable = 1'b1;
        step();
        set_req = '0;
        n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL en_set got %b exp 0101", flags); end
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL en_latency got %b exp 0", grant_valid); end
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL en_grant got v=%b id=%0d exp v=1 id=0", grant_valid, grant_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mask = 4'b1111; grant_ready = 1'b1; set_req = 4'b1111;
        step();
        set_req = '0;
        for (int k = 0; k < N; k++) begin
            logic [N-1:0] exp_f;
            step();
            n_checks++; if (grant_valid !== 1'b1 || grant_id !== IDW'(k)) begin
                n_fail++; $display("FAIL rr_grant%0d got v=%b id=%0d exp v=1 id=%0d", k, grant_valid, grant_id, k);
            end
            step();
            exp_f = 4'b1111 << (k + 1);
            n_checks++; if (grant_valid !== 1'b0 || flags !== exp_f) begin
                n_fail++; $display("FAIL rr_bubble%0d got v=%b f=%b exp v=0 f=%b", k, grant_valid, flags, exp_f);
            end
        end
        set_req = 4'b1111;
        step();
        set_req = '0;
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL rr_wrap got v=%b id=%0d exp v=1 id=0", grant_valid, grant_id);
        end
        step();
        grant_ready = 1'b0;
    endtask

    task automatic test_conflict();
        do_reset();
        set_req = 4'b0100; clr_req = 4'b0100;
        step();
        set_req = '0; clr_req = '0;
        n_checks++; if (flags[2] !== 1'b0 || conflict !== 4'b0100) begin
            n_fail++; $display("FAIL conflict_set got f2=%b c=%b exp f2=0 c=0100", flags[2], conflict);
        end
        step(); step();
        n_checks++; if (conflict !== 4'b0100) begin n_fail++; $display("FAIL conflict_sticky got %b exp 0100", conflict); end
        do_reset();
        n_checks++; if (conflict !== 4'b0000) begin n_fail++; $display("FAIL conflict_rst got %b exp 0000", conflict); end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req = 4'b0010;
        step();
        set_req = '0;
        step();
        for (int c = 0; c < 5; c++) begin
            set_req = (c % 2 == 0) ? 4'b0001 : 4'b0000;
            step();
            n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b id=%0d exp v=1 id=1", c, grant_valid, grant_id);
            end
        end
        set_req = '0; grant_ready = 1'b1;
        step();
        grant_ready = 1'b0;
        n_checks++; if (flags !== 4'b0001 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept got f=%b v=%b exp f=0001 v=0", flags, grant_valid);
        end
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            n_fail++; $display("FAIL bp_next got v=%b id=%0d exp v=1 id=0", grant_valid, grant_id);
        end
        grant_ready = 1'b1;
        step();
        grant_ready = 1'b0; set_req = 4'b1000;
        step();
        set_req = '0;
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++; $display("FAIL bp_id3 got v=%b id=%0d exp v=1 id=3", grant_valid, grant_id);
        end
        set_req = 4'b1000; grant_ready = 1'b1;
        step();
        set_req = '0; grant_ready = 1'b0;
        n_checks++; if (flags !== 4'b1000 || grant_valid !== 1'b0) begin
            n_fail++; $display("FAIL hs_set_wins got f=%b v=%b exp f=1000 v=0", flags, grant_valid);
        end
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++; $display("FAIL single_regrant got v=%b id=%0d exp v=1 id=3", grant_valid, grant_id);
        end
    endtask

    task automatic test_mask_reset();
        do_reset();
        mask = 4'b0000; set_req = 4'b0010;
        step();
        set_req = '0;
        repeat (3) step();
        n_checks++; if (pending !== 1'b0 || grant_valid !== 1'b0 || flags !== 4'b0010) begin
            n_fail++; $display("FAIL mask_zero got p=%b v=%b f=%b exp p=0 v=0 f=0010", pending, grant_valid, flags);
        end
        mask = 4'b0010;
        #1;
        n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL mask_pending got %b exp 1", pending); end
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++; $display("FAIL mask_grant got v=%b id=%0d exp v=1 id=1", grant_valid, grant_id);
        end
        mask = 4'b0000;
        step();
        n_checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
            n_fail++; $display("FAIL mask_nowithdraw got v=%b id=%0d exp v=1 id=1", grant_valid, grant_id);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (grant_valid !== 1'b0 || flags !== 4'b0000) begin
            n_fail++; $display("FAIL mid_rst got v=%b f=%b exp v=0 f=0000", grant_valid, flags);
        end
        mask = 4'b1111;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst         = ($urandom_range(0, 99) < 2);
            Enable      = ($urandom_range(0, 9) != 0);
            set_req     = N'($urandom) & N'($urandom);
            clr_req     = N'($urandom) & N'($urandom) & N'($urandom);
            grant_ready = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) mask = N'($urandom);
            step();
            n_checks++; if (flags !== m_flags) begin n_fail++; $display("FAIL rnd_flags c%0d got %b exp %b", c, flags, m_flags); end
            n_checks++; if (conflict !== m_conf) begin n_fail++; $display("FAIL rnd_conflict c%0d got %b exp %b", c, conflict, m_conf); end
            n_checks++; if (grant_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", c, grant_valid, m_valid); end
            n_checks++; if (pending !== |(m_flags & mask)) begin n_fail++; $display("FAIL rnd_pending c%0d got %b exp %b", c, pending, |(m_flags & mask)); end
            if (m_valid) begin
                n_checks++; if (grant_id !== IDW'(m_id)) begin n_fail++; $display("FAIL rnd_id c%0d got %0d exp %0d", c, grant_id, m_id); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        m_flags = '0; m_conf = '0; m_valid = 1'b0; m_id = 0; m_ptr = N - 1;
        rst = 1'b1; Enable = 1'b1; set_req = '0; clr_req = '0; mask = '1; grant_ready = 1'b0;
        test_reset();
        test_enable_gating();
        test_round_robin();
        test_conflict();
        test_backpressure();
        test_mask_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
